// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Load/store front end placed directly in front of a single-ported Memory.
// Stores are queued in a small in-order FIFO and drained one per cycle to the
// port. Loads use the port directly when no buffered store overlaps their
// bytes. Load data is sign- or zero-extended and returned one cycle after the
// load is accepted.
//
// Parameters
//   DEPTH         number of store entries (power of two, >= 2)
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   st_valid      store request            st_ready   store accepted (not full)
//   st_addr       store byte address       st_data    LSB-aligned store data
//   st_length     0=byte 1=half 2=word (>=3 treated as word)
//   ld_valid      load request             ld_ready   load accepted this cycle
//   ld_addr       load byte address        ld_length  same encoding as st_length
//   ld_unsigned   1 = zero-extend
//   ld_rvalid     one-cycle pulse, ld_rdata valid
//   ld_rdata      extended load result
//   mem_hold      port owned by another master this cycle
//   sb_empty      no buffered stores
//   address, wr_data, wr_enable, write_length   to Memory
//   read_data     from Memory (combinational, little-endian)
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_length,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_length,
  input  logic        ld_unsigned,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,
  input  logic        mem_hold,
  output logic        sb_empty,
  output logic [31:0] address,
  output logic [31:0] wr_data,
  output logic        wr_enable,
  output logic [2:0]  write_length,
  input  logic [31:0] read_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage (datapath only, never needs a reset value).
  logic [31:0]   ent_addr_r [DEPTH];
  logic [31:0]   ent_data_r [DEPTH];
  logic [1:0]    ent_len_r  [DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          full_s;
  logic          empty_s;
  logic          overlap_s;
  logic          st_fire_s;
  logic          ld_fire_s;
  logic          drain_s;
  logic [32:0]   ld_end_s;
  logic [31:0]   ld_ext_s;

  logic          ld_rvalid_r;
  logic [31:0]   ld_rdata_r;

  // Sizes >= 3 collapse to a word access.
  function automatic logic [1:0] norm_len(input logic [2:0] len);
    logic [1:0] r;
    if (len >= 3'd3) begin
      r = 2'd2;
    end else begin
      r = len[1:0];
    end
    return r;
  endfunction

  // Last byte address of an access, kept in 33 bits so the range cannot wrap.
  function automatic logic [32:0] span_end(input logic [31:0] a, input logic [1:0] len);
    logic [32:0] r;
    case (len)
      2'd0:    r = {1'b0, a};
      2'd1:    r = {1'b0, a} + 33'd1;
      default: r = {1'b0, a} + 33'd3;
    endcase
    return r;
  endfunction

  // Sign/zero extension of the raw little-endian memory word.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] len,
                                         input logic uns);
    logic [31:0] r;
    case (len)
      2'd0: begin
        if (uns) begin
          r = {24'd0, d[7:0]};
        end else begin
          r = {{24{d[7]}}, d[7:0]};
        end
      end
      2'd1: begin
        if (uns) begin
          r = {16'd0, d[15:0]};
        end else begin
          r = {{16{d[15]}}, d[15:0]};
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign full_s   = (count_r == CW'(DEPTH));
  assign empty_s  = (count_r == {CW{1'b0}});
  assign ld_end_s = span_end(ld_addr, norm_len(ld_length));
  assign ld_ext_s = extend(read_data, norm_len(ld_length), ld_unsigned);

  // Overlap search: a slot is live when its distance from the head is below count.
  always_comb begin
    overlap_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, AW'(i) - rd_ptr_r} < count_r) begin
        if (({1'b0, ent_addr_r[i]} <= ld_end_s) &&
            ({1'b0, ld_addr} <= span_end(ent_addr_r[i], ent_len_r[i]))) begin
          overlap_s = 1'b1;
        end else begin
          overlap_s = overlap_s;
        end
      end else begin
        overlap_s = overlap_s;
      end
    end
  end

  // Handshakes and port arbitration: hold > load > drain > idle.
  always_comb begin
    st_fire_s = st_valid && !full_s;
    ld_ready  = !mem_hold && !st_valid && !full_s && !overlap_s;
    ld_fire_s = ld_valid && ld_ready;
    if (mem_hold || ld_fire_s || empty_s) begin
      drain_s = 1'b0;
    end else begin
      drain_s = 1'b1;
    end
  end

  // Memory port drive: head entry by default, load address on a read cycle.
  always_comb begin
    wr_data      = ent_data_r[rd_ptr_r];
    write_length = {1'b0, ent_len_r[rd_ptr_r]};
    wr_enable    = drain_s;
    if (ld_fire_s) begin
      address = ld_addr;
    end else begin
      address = ent_addr_r[rd_ptr_r];
    end
  end

  // Entry write on store acceptance.
  always_ff @(posedge clk) begin
    if (st_fire_s) begin
      ent_addr_r[wr_ptr_r] <= st_addr;
      ent_data_r[wr_ptr_r] <= st_data;
      ent_len_r[wr_ptr_r]  <= norm_len(st_length);
    end
  end

  // FIFO pointers and occupancy; simultaneous push and drain keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (st_fire_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (drain_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({st_fire_s, drain_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Load response register: data captured at the edge ending the read cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_rvalid_r <= 1'b0;
      ld_rdata_r  <= 32'd0;
    end else begin
      ld_rvalid_r <= ld_fire_s;
      if (ld_fire_s) begin
        ld_rdata_r <= ld_ext_s;
      end
    end
  end

  assign st_ready  = !full_s;
  assign sb_empty  = empty_s;
  assign ld_rvalid = ld_rvalid_r;
  assign ld_rdata  = ld_rdata_r;

endmodule
